// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data memory for the CPU load/store port, with a one-cycle ready strobe.
// Optional feature macro DMEM_RANGE_CHECK_EN: out-of-range addresses raise err instead of wrapping.
module dmem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);
  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_ready;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_req;
  logic              w_go_resp;
  logic              w_wr_eff;
  logic              w_oor;
  logic              w_commit;
  logic [ADDR_W-1:0] w_addr_eff;
  logic [DATA_W-1:0] w_wdata_eff;
  logic [IDX_W-1:0]  w_idx;

  assign w_req = mem_read | mem_write;

  // A zero-wait access responds on its accept edge, before the latches load, so it uses the live inputs.
  assign w_go_resp   = ((r_state == S_IDLE) && w_req && (WAIT_CYCLES == 0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_addr_eff  = (r_state == S_IDLE) ? addr      : r_addr;
  assign w_wdata_eff = (r_state == S_IDLE) ? wdata     : r_wdata;
  assign w_wr_eff    = (r_state == S_IDLE) ? mem_write : r_wr;
  assign w_idx       = w_addr_eff[IDX_W-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  assign w_oor = ({1'b0, w_addr_eff} >= DEPTH_L);
`else
  assign w_oor = 1'b0;
`endif

  // Gating with rst_n keeps a write arriving under reset from reaching the array.
  assign w_commit = w_go_resp & w_wr_eff & ~w_oor & rst_n;

  assign busy  = w_req & ~r_ready;
  assign ready = r_ready;
  assign rdata = r_rdata;

  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && w_req) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_wr    <= mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_idx] <= w_wdata_eff;
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_rdata <= '0;
`ifdef DMEM_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_ready <= w_go_resp;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_go_resp && !w_wr_eff) r_rdata <= r_mem[w_idx];
`ifdef DMEM_RANGE_CHECK_EN
      r_err <= w_go_resp & w_oor;
      if (w_go_resp && w_oor) r_rdata <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: instance A (DEPTH=128, 2 wait states) and B (DEPTH=256, zero wait).
// Expected values come from a word-level memory model indexed by plain modulo arithmetic.
module tb_dmem_responder;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd_a, wr_a, ready_a, busy_a, err_a;
  logic [7:0]  addr_a;
  logic [15:0] wdata_a, rdata_a;
  logic        rd_b, wr_b, ready_b, busy_b, err_b;
  logic [7:0]  addr_b;
  logic [15:0] wdata_b, rdata_b;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .mem_read(rd_a), .mem_write(wr_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .busy(busy_a), .err(err_a));

  dmem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .mem_read(rd_b), .mem_write(wr_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .busy(busy_b), .err(err_b));

  // Reference model: per-instance word arrays plus the last value a read returned.
  logic [15:0] m_mem [2][256];
  bit          m_known [2][256];
  logic [15:0] m_last [2];
  bit          m_last_known [2];

  logic [15:0] ard, erd;
  logic        aerr, eerr;
  int          lat;
  bit          bok, eknown;

  function automatic int depth_of(input bit sel);
    return sel ? 256 : 128;
  endfunction

  function automatic int wait_of(input bit sel);
    return sel ? 0 : 2;
  endfunction

  function automatic logic f_ready(input bit sel);
    return sel ? ready_b : ready_a;
  endfunction

  function automatic logic f_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  task automatic drive(input bit sel, input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
    if (sel) begin rd_b = r; wr_b = w; addr_b = a; wdata_b = d; end
    else     begin rd_a = r; wr_a = w; addr_a = a; wdata_a = d; end
  endtask

  task automatic model_step(input bit sel, input bit wr, input logic [7:0] a, input logic [15:0] d,
                            output logic [15:0] exp_rd, output bit exp_known, output logic exp_err);
    int  i;
    bit  oor;
    i   = int'(a) % depth_of(sel);
    oor = RC && (int'(a) >= depth_of(sel));
    if (oor) begin
      m_last[sel] = 16'h0; m_last_known[sel] = 1'b1;
    end else if (wr) begin
      m_mem[sel][i] = d; m_known[sel][i] = 1'b1;
    end else begin
      m_last[sel] = m_mem[sel][i]; m_last_known[sel] = m_known[sel][i];
    end
    exp_rd = m_last[sel]; exp_known = m_last_known[sel]; exp_err = oor;
  endtask

  // One complete access; inputs are scrambled after accept to show they are ignored.
  task automatic access(input bit sel, input logic r, input logic w, input logic [7:0] a, input logic [15:0] d,
                        input bit drop);
    int edges;
    bit got;
    bok = 1'b1; edges = 0; got = 1'b0;
    @(negedge clk);
    drive(sel, r, w, a, d);
    #1;
    if (f_busy(sel) !== 1'b1) bok = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (f_ready(sel) === 1'b1) begin
        got = 1'b1;
      end else begin
        drive(sel, drop ? 1'b0 : r, drop ? 1'b0 : w, 8'($urandom), 16'($urandom));
        #1;
        if (f_busy(sel) !== (drop ? 1'b0 : 1'b1)) bok = 1'b0;
      end
    end
    lat  = got ? edges : -1;
    ard  = sel ? rdata_b : rdata_a;
    aerr = sel ? err_b : err_a;
    if (got && f_busy(sel) !== 1'b0) bok = 1'b0;
    drive(sel, 1'b0, 1'b0, 8'h00, 16'h0000);
    model_step(sel, bit'(w), a, d, erd, eknown, eerr);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ready_a); end
    checks++; if (rdata_a !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h want 0000", rdata_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy_idle got %b want 0", busy_a); end
    rd_a = 1'b1; #1;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_busy_req got %b want 1", busy_a); end
    rd_a = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    access(0, 1'b0, 1'b1, 8'h20, 16'h1111, 1'b0);
    access(0, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0);
    checks++; if (ard !== 16'h1111) begin errors++; $display("FAIL rst_pre_read got %h want 1111", ard); end
    // Write accepted, then reset lands while it is waiting.
    @(negedge clk); drive(0, 1'b0, 1'b1, 8'h20, 16'h5555);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0; #1;
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b want 0", ready_a); end
    checks++; if (rdata_a !== 16'h0) begin errors++; $display("FAIL rst_mid_rdata got %h want 0000", rdata_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %b want 1", busy_a); end
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    m_last[0] = 16'h0; m_last_known[0] = 1'b1; m_last[1] = 16'h0; m_last_known[1] = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    access(0, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0);
    checks++; if (ard !== 16'h1111) begin errors++; $display("FAIL rst_lost_write got %h want 1111", ard); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL rst_after_lat got %0d want 3", lat); end
  endtask

  task automatic test_basic;
    access(0, 1'b0, 1'b1, 8'h05, 16'h1234, 1'b0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_wr_lat got %0d want 3", lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_wr_busy got %b want 1", bok); end
    checks++; if (ard !== 16'h1111) begin errors++; $display("FAIL basic_wr_hold got %h want 1111", ard); end
    access(0, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_rd_lat got %0d want 3", lat); end
    checks++; if (ard !== 16'h1234) begin errors++; $display("FAIL basic_rd_data got %h want 1234", ard); end
  endtask

  task automatic test_zero_wait;
    access(1, 1'b0, 1'b1, 8'h00, 16'hBEEF, 1'b0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zw_wr_lat got %0d want 1", lat); end
    access(1, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zw_rd_lat got %0d want 1", lat); end
    checks++; if (ard !== 16'hBEEF) begin errors++; $display("FAIL zw_rd_data got %h want beef", ard); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL zw_busy got %b want 1", bok); end
  endtask

  task automatic test_both_high;
    access(0, 1'b1, 1'b1, 8'h10, 16'h00AA, 1'b0);
    access(0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0);
    checks++; if (ard !== 16'h00AA) begin errors++; $display("FAIL both_high got %h want 00aa", ard); end
  endtask

  task automatic test_inputs_ignored;
    access(0, 1'b0, 1'b1, 8'h31, 16'h0101, 1'b0);
    access(0, 1'b0, 1'b1, 8'h30, 16'h7777, 1'b1);
    access(0, 1'b1, 1'b0, 8'h30, 16'h0000, 1'b0);
    checks++; if (ard !== 16'h7777) begin errors++; $display("FAIL ignore_latched got %h want 7777", ard); end
    access(0, 1'b1, 1'b0, 8'h31, 16'h0000, 1'b0);
    checks++; if (ard !== 16'h0101) begin errors++; $display("FAIL ignore_neighbour got %h want 0101", ard); end
  endtask

  task automatic test_range;
    access(0, 1'b0, 1'b1, 8'h05, 16'h4242, 1'b0);
    access(0, 1'b0, 1'b1, 8'h85, 16'hDEAD, 1'b0);
    checks++; if (aerr !== RC) begin errors++; $display("FAIL range_wr_err got %b want %b", aerr, RC); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL range_wr_lat got %0d want 3", lat); end
    access(0, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0);
    checks++; if (ard !== (RC ? 16'h4242 : 16'hDEAD)) begin errors++; $display("FAIL range_low got %h want %h", ard, RC ? 16'h4242 : 16'hDEAD); end
    access(0, 1'b1, 1'b0, 8'h85, 16'h0000, 1'b0);
    checks++; if (ard !== (RC ? 16'h0000 : 16'hDEAD)) begin errors++; $display("FAIL range_high got %h want %h", ard, RC ? 16'h0000 : 16'hDEAD); end
    checks++; if (aerr !== RC) begin errors++; $display("FAIL range_rd_err got %b want %b", aerr, RC); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pool [6];
    pool[0] = 8'h03; pool[1] = 8'h83; pool[2] = 8'h40; pool[3] = 8'hC0; pool[4] = 8'h7F; pool[5] = 8'hFF;
    for (int n = 0; n < 60; n++) begin
      bit         sel, drop;
      int         op;
      logic [7:0] a;
      sel  = 1'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 2));
      drop = ($urandom_range(0, 3) == 0);
      a    = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)] : 8'($urandom);
      access(sel, op != 1, op != 0, a, 16'($urandom), drop);
      checks++; if (lat !== wait_of(sel) + 1) begin errors++; $display("FAIL b2b_lat[%0d] got %0d want %0d", n, lat, wait_of(sel) + 1); end
      checks++; if (bok !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got %b want 1", n, bok); end
      checks++; if (aerr !== eerr) begin errors++; $display("FAIL b2b_err[%0d] got %b want %b", n, aerr, eerr); end
      if (eknown) begin
        checks++; if (ard !== erd) begin errors++; $display("FAIL b2b_rdata[%0d] got %h want %h", n, ard, erd); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    for (int s = 0; s < 2; s++) begin
      m_last[s] = 16'h0; m_last_known[s] = 1'b1;
      for (int i = 0; i < 256; i++) begin m_mem[s][i] = 16'h0; m_known[s][i] = 1'b0; end
    end
    repeat (2) @(posedge clk);
    test_reset;
    test_basic;
    test_zero_wait;
    test_both_high;
    test_inputs_ignored;
    test_range;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
